// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter.
//   - state_t  : arbiter FSM encoding (IDLE / ISSUE / WAIT)
//   - req_id_t : requester identity, also used as the round-robin pointer
//   - DEF_DATA_W / DEF_ADDR_W : default data and address widths
package mem_arbiter_pkg;

  localparam int DEF_DATA_W = 18;
  localparam int DEF_ADDR_W = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single shared memory port.
// One transaction is served at a time: IDLE grants, ISSUE drives the
// memory command for one cycle, and reads then sit in WAIT for RD_LAT
// cycles before the returned word is handed to the requester.
//
// Ports
//   clk, rst                    : clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata   : requester A command (held until a_ack)
//   a_ack, a_rdata, a_rvalid    : requester A issue pulse, read data, data-valid pulse
//   b_*                         : same for requester B
//   mem_addr, mem_wdata         : shared memory address / write data
//   mem_re, mem_we              : shared memory read / write strobes (ISSUE only)
//   mem_rdata                   : shared memory read data, valid RD_LAT cycles after mem_re
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

  state_t            state, state_nxt;
  req_id_t           prio, prio_nxt;
  req_id_t           owner, owner_nxt;
  logic              op_we, op_we_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              grant_b;

  logic              a_ack_nxt, b_ack_nxt, a_rvalid_nxt, b_rvalid_nxt;
  logic              mem_re_nxt, mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt, a_rdata_nxt, b_rdata_nxt;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_nxt     = state;
    prio_nxt      = prio;
    owner_nxt     = owner;
    op_we_nxt     = op_we;
    cnt_nxt       = cnt;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    a_rdata_nxt   = a_rdata;
    b_rdata_nxt   = b_rdata;
    a_ack_nxt     = 1'b0;
    b_ack_nxt     = 1'b0;
    a_rvalid_nxt  = 1'b0;
    b_rvalid_nxt  = 1'b0;
    mem_re_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    // B wins when it is the only requester, or on a tie when it holds priority.
    grant_b       = b_req && (!a_req || (prio == REQ_B));

    unique case (state)
      ST_IDLE: begin
        if (a_req || b_req) begin
          owner_nxt     = grant_b ? REQ_B : REQ_A;
          prio_nxt      = grant_b ? REQ_A : REQ_B;
          op_we_nxt     = grant_b ? b_we    : a_we;
          mem_addr_nxt  = grant_b ? b_addr  : a_addr;
          mem_wdata_nxt = grant_b ? b_wdata : a_wdata;
          // Ack and strobes are registered so they line up with the ISSUE cycle.
          a_ack_nxt     = !grant_b;
          b_ack_nxt     = grant_b;
          mem_we_nxt    = op_we_nxt;
          mem_re_nxt    = !op_we_nxt;
          state_nxt     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = op_we ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt == CNT_LAST) begin
          state_nxt = ST_IDLE;
          if (owner == REQ_B) begin
            b_rdata_nxt  = mem_rdata;
            b_rvalid_nxt = 1'b1;
          end else begin
            a_rdata_nxt  = mem_rdata;
            a_rvalid_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state     <= ST_IDLE;
      prio      <= REQ_A;
      owner     <= REQ_A;
      op_we     <= 1'b0;
      cnt       <= '0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nxt;
      prio      <= prio_nxt;
      owner     <= owner_nxt;
      op_we     <= op_we_nxt;
      cnt       <= cnt_nxt;
      a_ack     <= a_ack_nxt;
      b_ack     <= b_ack_nxt;
      a_rvalid  <= a_rvalid_nxt;
      b_rvalid  <= b_rvalid_nxt;
      a_rdata   <= a_rdata_nxt;
      b_rdata   <= b_rdata_nxt;
      mem_re    <= mem_re_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter paired with a single-port memory model (RD_LAT=1).
// A transaction-level model predicts, per cycle, the ack / strobe / rvalid
// pulses and the held read data; a compare process checks them on every
// negative clock edge. Directed scenarios add hand-computed literal checks.
module tb_mem_arbiter;

  localparam int DW  = 18;
  localparam int AW  = 13;
  localparam int LAT = 1;

  logic          clk, rst;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr, mem_addr;
  logic [DW-1:0] a_wdata, b_wdata, mem_wdata, mem_rdata, a_rdata, b_rdata;
  logic          a_ack, b_ack, a_rvalid, b_rvalid, mem_re, mem_we;

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read, one cycle of latency.
  logic [DW-1:0] tb_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= tb_mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [DW-1:0] model_mem [0:(1<<AW)-1];
  bit            model_ok = 1'b0;
  bit            m_prio;                 // 0 = a next on a tie, 1 = b
  int            free_cyc, iss_cyc, rv_cyc, zero_cyc;
  bit            iss_who, iss_we, rv_who, win_b;
  logic [AW-1:0] iss_addr;
  logic [DW-1:0] iss_wdata, rv_data, exp_rdata_a, exp_rdata_b;

  always @(negedge clk) begin
    if (model_ok) begin
      if (cyc == rv_cyc) begin
        if (rv_who) exp_rdata_b = rv_data;
        else        exp_rdata_a = rv_data;
      end
      check("a_ack",    a_ack,    (cyc == iss_cyc) && !iss_who);
      check("b_ack",    b_ack,    (cyc == iss_cyc) &&  iss_who);
      check("mem_we",   mem_we,   (cyc == iss_cyc) &&  iss_we);
      check("mem_re",   mem_re,   (cyc == iss_cyc) && !iss_we);
      check("a_rvalid", a_rvalid, (cyc == rv_cyc) && !rv_who);
      check("b_rvalid", b_rvalid, (cyc == rv_cyc) &&  rv_who);
      check("a_rdata",  a_rdata,  exp_rdata_a);
      check("b_rdata",  b_rdata,  exp_rdata_b);
      check("re_we_excl", mem_re && mem_we, 0);
      if (cyc == iss_cyc) begin
        check("mem_addr",  mem_addr,  iss_addr);
        check("mem_wdata", mem_wdata, iss_wdata);
      end
      if (cyc == zero_cyc) begin
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_mem_wdata", mem_wdata, 0);
      end
    end
    if (rst) begin
      model_ok    = 1'b1;
      m_prio      = 1'b0;
      free_cyc    = cyc + 1;
      iss_cyc     = -1;
      rv_cyc      = -1;
      zero_cyc    = cyc + 1;
      exp_rdata_a = '0;
      exp_rdata_b = '0;
    end else if (model_ok && cyc >= free_cyc && (a_req || b_req)) begin
      win_b     = b_req && (!a_req || m_prio);
      m_prio    = !win_b;
      iss_who   = win_b;
      iss_we    = win_b ? b_we    : a_we;
      iss_addr  = win_b ? b_addr  : a_addr;
      iss_wdata = win_b ? b_wdata : a_wdata;
      iss_cyc   = cyc + 1;
      if (iss_we) begin
        model_mem[iss_addr] = iss_wdata;
        free_cyc = cyc + 2;
      end else begin
        rv_who   = win_b;
        rv_data  = model_mem[iss_addr];
        rv_cyc   = cyc + 2 + LAT;
        free_cyc = cyc + 2 + LAT;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Drives a command, waits for its ack (bounded), drops req in the ack cycle.
  // Returns at the negedge of the ack cycle.
  task automatic issue(input bit who, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, output int req_c, output int ack_c);
    req_c = cyc;
    ack_c = -1;
    if (who) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = data; end
    else     begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = data; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (who ? b_ack : a_ack) begin ack_c = cyc; break; end
    end
    if (who) b_req = 1'b0; else a_req = 1'b0;
    if (ack_c < 0) check("ack_seen", 0, 1);
  endtask

  task automatic wait_rvalid(input bit who, output int rv_c);
    rv_c = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (who ? b_rvalid : a_rvalid) begin rv_c = cyc; break; end
    end
    if (rv_c < 0) check("rvalid_seen", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int            rq, ak, rv, n, nb, nrv, cnt_ev;
  bit            order [4];
  logic [DW-1:0] rvd [4];

  initial begin
    rst = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      tb_mem[i]    = DW'(20 + i);
      model_mem[i] = DW'(20 + i);
    end
    repeat (3) sync();

    // Reset state, literal expectations.
    @(negedge clk);
    check("rst_a_ack", a_ack, 0);
    check("rst_b_rvalid", b_rvalid, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_mem_re_we", {mem_re, mem_we}, 0);

    // Write-only: first IDLE after reset grants immediately.
    sync();
    rst = 1'b0;
    issue(1'b0, 1'b1, AW'(5), DW'(10), rq, ak);
    check("wr_ack_lat", ak - rq, 1);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", mem_addr, 5);
    check("wr_mem_wdata", mem_wdata, 10);
    @(negedge clk);
    check("wr_we_one_cycle", mem_we, 0);

    // Read-back of the same address.
    sync();
    issue(1'b0, 1'b0, AW'(5), DW'(0), rq, ak);
    check("rd_mem_re", mem_re, 1);
    wait_rvalid(1'b0, rv);
    check("rd_rvalid_lat", rv - ak, 2);
    check("rd_a_rdata", a_rdata, 10);
    check("rd_b_rvalid", b_rvalid, 0);

    // Contention from reset: both held, grants alternate a,b,a,b.
    sync(); rst = 1'b1;
    sync(); rst = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = AW'(100); a_wdata = DW'(1);
    b_req = 1'b1; b_we = 1'b1; b_addr = AW'(200); b_wdata = DW'(2);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_ack && n < 4) begin order[n] = 1'b0; n++; end
      if (b_ack && n < 4) begin order[n] = 1'b1; n++; end
    end
    a_req = 1'b0; b_req = 1'b0;
    check("cont_grants", n, 4);
    for (int i = 0; i < 4; i++) check("cont_order", order[i], i % 2);

    // Back-to-back reads by b from preloaded addresses 0..3.
    sync();
    b_req = 1'b1; b_we = 1'b0; b_addr = '0;
    nb = 0; nrv = 0;
    for (int i = 0; i < 40 && nrv < 4; i++) begin
      @(negedge clk);
      if (b_ack) begin
        nb++;
        if (nb == 4) b_req = 1'b0; else b_addr = AW'(nb);
      end
      if (b_rvalid) begin rvd[nrv] = b_rdata; nrv++; end
    end
    b_req = 1'b0;
    check("b2b_count", nrv, 4);
    for (int i = 0; i < 4; i++) check("b2b_data", rvd[i], 32'(20 + i));

    // Withdrawn request: b pulses only during a's WAIT cycle.
    sync();
    issue(1'b0, 1'b0, AW'(5), DW'(0), rq, ak);
    sync(); b_req = 1'b1; b_we = 1'b0; b_addr = AW'(1);
    sync(); b_req = 1'b0;
    cnt_ev = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b_ack) cnt_ev++;
    end
    check("withdrawn_b_acks", cnt_ev, 0);
    check("withdrawn_a_rdata", a_rdata, 10);

    // Reset during WAIT aborts the read.
    sync();
    issue(1'b0, 1'b0, AW'(5), DW'(0), rq, ak);
    sync(); rst = 1'b1;
    sync(); rst = 1'b0;
    @(negedge clk);
    check("abort_a_rdata", a_rdata, 0);
    check("abort_outputs", {a_ack, b_ack, a_rvalid, b_rvalid, mem_re, mem_we}, 0);
    check("abort_mem_addr", mem_addr, 0);
    cnt_ev = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a_rvalid) cnt_ev++;
    end
    check("abort_no_rvalid", cnt_ev, 0);
    sync();
    issue(1'b1, 1'b1, AW'(7), DW'(3), rq, ak);
    check("post_rst_ack_lat", ak - rq, 1);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
